spram_be_ctrl: RTL

//  Parametrised single-port RAM with byte-enable writes and a valid/ready request port.

---
 rtl/spram_be_ctrl_pkg.sv | 26 ++
 rtl/spram_be_ctrl_array.sv | 36 +++
 rtl/spram_be_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spram_be_ctrl_pkg.sv
// Shared types and helpers for the byte-enable single-port RAM controller.
// be_merge works on words up to MERGE_W bits; callers zero-extend narrower words.
package spram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } spram_state_e;

  localparam int unsigned MERGE_W  = 1024;
  localparam int unsigned MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]  old_w,
    input logic [MERGE_W-1:0]  new_w,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MERGE_BE); i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/spram_be_ctrl_array.sv
// Storage for spram_be_ctrl: one access per cycle, per-byte write enables, registered read.
// Deliberately unreset so it maps onto an SRAM macro.
module spram_array #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < int'(BE_W); i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spram_be_ctrl.sv
// Single-port RAM front end: valid/ready request port, clear engine and read-latency pipeline.
// The clear engine owns the array while busy; requests are only accepted in ST_IDLE.
module spram_be_ctrl
  import spram_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 14,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int unsigned      BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [BE_W-1:0]   req_be_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              clr_done_o
);

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  spram_state_e      state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic              accept;
  logic              rd_accept;
  logic              rd_v1_q;

  logic              arr_en;
  logic              arr_we;
  logic [BE_W-1:0]   arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // clr_addr wraps back to 0 on the last clear write, so no explicit reload is needed there.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    req_ready_o = 1'b0;
    clr_busy_o  = 1'b0;
    clr_done_o  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_busy_o = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == CLR_LAST) begin
          clr_done_o = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (clr_start_i) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  assign accept    = req_valid_i & req_ready_o;
  assign rd_accept = accept & ~req_we_i;

  always_comb begin
    arr_en    = accept;
    arr_we    = req_we_i;
    arr_be    = req_be_i;
    arr_addr  = req_addr_i;
    arr_wdata = req_wdata_i;
    if (clr_busy_o) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = clr_addr_q;
      arr_wdata = INIT_VAL;
    end
  end

  spram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_v1_q <= 1'b0;
    else       rd_v1_q <= rd_accept;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              rsp_v_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rsp_v_q     <= 1'b0;
        rsp_rdata_q <= '0;
      end else begin
        rsp_v_q <= rd_v1_q;
        if (rd_v1_q) rsp_rdata_q <= arr_rdata;
      end
    end

    assign rsp_valid_o = rsp_v_q;
    assign rsp_rdata_o = rsp_rdata_q;
  end else begin : g_lat1
    // The array output register is unreset; mask it until a read has been issued since reset.
    logic seen_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          seen_q <= 1'b0;
      else if (rd_accept) seen_q <= 1'b1;
    end

    assign rsp_valid_o = rd_v1_q;
    assign rsp_rdata_o = seen_q ? arr_rdata : '0;
  end

endmodule
